// File: rtl/sword_pkg.sv
// Shared definitions for the sword duel round controller.
// Contents: duel state encoding, player-index width helper and the default
// countdown / GO-window lengths used as parameter defaults by sword_duel_ctrl.
package sword_pkg;

  localparam int unsigned DEF_DELAY_CYCLES   = 16;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    GO   = 2'd2,
    DONE = 2'd3
  } duel_state_t;

  // Bits needed to index n players (never less than one bit).
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/sword_rr_arbiter.sv
// Combinational round-robin arbiter for simultaneous sword presses.
// Scans req starting at index ptr, upward with wrap, and grants the first set bit.
// Ports:
//   req       in  N      request vector (eligible presses)
//   ptr       in  IDX_W  highest-priority index for this scan
//   gnt_valid out 1      at least one request present
//   gnt_idx   out IDX_W  granted index, meaningful only with gnt_valid
module sword_rr_arbiter
  import sword_pkg::*;
#(
  parameter  int unsigned N     = 4,
  localparam int unsigned IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx
);

  // First requester found in the rotated scan order wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!gnt_valid && req[IDX_W'((32'(ptr) + i) % N)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IDX_W'((32'(ptr) + i) % N);
      end
    end
  end

endmodule

// File: rtl/sword_duel_ctrl.sv
// Round controller for one sword duel between N_PLAYERS players.
// Arms a round, runs a DELAY_CYCLES countdown (presses there are fouls), raises
// go for up to TIMEOUT_CYCLES cycles and records the first legal press as the
// winner; ties are broken round-robin.
// Optional feature macro: SWORD_DUEL_SCORE_EN adds saturating per-player score
// counters and the score port.
// Ports:
//   clk          in  1                  rising-edge clock
//   reset        in  1                  synchronous, active-high
//   start        in  1                  begin a round (IDLE/DONE only)
//   sw           in  N_PLAYERS          per-player sword press level
//   busy         out 1                  round in progress (ARM or GO)
//   go           out 1                  GO window open
//   done         out 1                  round finished
//   winner_valid out 1                  round produced a winner
//   winner_id    out IDX_W              winner index
//   foul         out N_PLAYERS          players that pressed during the countdown
//   score        out N_PLAYERS*SCORE_W  per-player wins (SWORD_DUEL_SCORE_EN only)
module sword_duel_ctrl
  import sword_pkg::*;
#(
  parameter  int unsigned N_PLAYERS      = 4,
  parameter  int unsigned DELAY_CYCLES   = DEF_DELAY_CYCLES,
  parameter  int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter  int unsigned SCORE_W        = 4,
  localparam int unsigned IDX_W          = idx_w(N_PLAYERS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [N_PLAYERS-1:0] sw,
  output logic                 busy,
  output logic                 go,
  output logic                 done,
  output logic                 winner_valid,
  output logic [IDX_W-1:0]     winner_id,
  output logic [N_PLAYERS-1:0] foul
`ifdef SWORD_DUEL_SCORE_EN
  ,
  output logic [N_PLAYERS*SCORE_W-1:0] score
`endif
);

  localparam int unsigned CNT_MAX = (DELAY_CYCLES > TIMEOUT_CYCLES) ? DELAY_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? 32'($clog2(CNT_MAX)) : 32'd1;

  duel_state_t            state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [N_PLAYERS-1:0]   foul_d;
  logic                   winner_valid_d;
  logic [IDX_W-1:0]       winner_id_d;
  logic [N_PLAYERS-1:0]   foul_acc;
  logic                   gnt_valid;
  logic [IDX_W-1:0]       gnt_idx;

  // Fouls accumulated including this cycle's presses.
  assign foul_acc = foul | sw;

  // Only players without a foul may win.
  sword_rr_arbiter #(
    .N (N_PLAYERS)
  ) u_arb (
    .req       (sw & ~foul),
    .ptr       (ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Next-state, counter, foul, pointer and result logic.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    ptr_d          = ptr_q;
    foul_d         = foul;
    winner_valid_d = winner_valid;
    winner_id_d    = winner_id;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d        = ARM;
          cnt_d          = CNT_W'(DELAY_CYCLES - 1);
          foul_d         = '0;
          winner_valid_d = 1'b0;
          winner_id_d    = '0;
        end
      end
      ARM: begin
        foul_d = foul_acc;
        // Everyone fouled: nobody can win, end the round without a GO window.
        if (&foul_acc) begin
          state_d = DONE;
        end else if (cnt_q == '0) begin
          state_d = GO;
          cnt_d   = CNT_W'(TIMEOUT_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GO: begin
        if (gnt_valid) begin
          state_d        = DONE;
          winner_valid_d = 1'b1;
          winner_id_d    = gnt_idx;
          ptr_d          = (gnt_idx == IDX_W'(N_PLAYERS - 1)) ? '0 : gnt_idx + IDX_W'(1);
        end else if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; status outputs are decoded from the next state so they
  // change in the same cycle as the state itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ptr_q        <= '0;
      foul         <= '0;
      winner_valid <= 1'b0;
      winner_id    <= '0;
      busy         <= 1'b0;
      go           <= 1'b0;
      done         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      foul         <= foul_d;
      winner_valid <= winner_valid_d;
      winner_id    <= winner_id_d;
      busy         <= (state_d == ARM) || (state_d == GO);
      go           <= (state_d == GO);
      done         <= (state_d == DONE);
    end
  end

`ifdef SWORD_DUEL_SCORE_EN
  logic [N_PLAYERS-1:0][SCORE_W-1:0] score_q;

  // Winner's counter bumps on entry to DONE, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      score_q <= '0;
    end else if ((state_q == GO) && gnt_valid && (score_q[gnt_idx] != '1)) begin
      score_q[gnt_idx] <= score_q[gnt_idx] + SCORE_W'(1);
    end
  end

  assign score = score_q;
`else
  logic unused_score_w;
  assign unused_score_w = ^SCORE_W;
`endif

endmodule
